// File: rtl/mem_access_if.sv
// Request, result and bus-side signals of the memory access unit, bundled
// so the core and its requester/bus agent share one connection.
interface mem_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  enabled;
  logic [2:0]            op;
  logic [1:0]            size;
  logic                  uns;
  logic [3:0]            amo_fn;
  logic [ADDR_W-1:0]     addr_in;
  logic [DATA_W-1:0]     wdata_in;
  logic                  completed;
  logic [DATA_W-1:0]     result;
  logic                  fault;
  logic [2:0]            fault_cause;
  logic                  req_en;
  logic                  req_mode;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  rsp_en;
  logic [DATA_W-1:0]     rsp_data;

  // The memory access unit itself
  modport slave (
    input  enabled, op, size, uns, amo_fn, addr_in, wdata_in, rsp_en, rsp_data,
    output completed, result, fault, fault_cause,
    output req_en, req_mode, req_addr, req_wdata, req_wstrb
  );

  // The requester plus the bus agent answering the unit
  modport master (
    output enabled, op, size, uns, amo_fn, addr_in, wdata_in, rsp_en, rsp_data,
    input  completed, result, fault, fault_cause,
    input  req_en, req_mode, req_addr, req_wdata, req_wstrb
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: turns load/store/LR/SC/AMO requests into aligned bus
// reads and writes, checks alignment/legality, tracks one LR reservation and
// gives up on the bus after TIMEOUT silent cycles.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rstn,
  mem_access_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_LR    = 3'd3;
  localparam logic [2:0] OP_SC    = 3'd4;
  localparam logic [2:0] OP_AMO   = 3'd5;

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, AMO_RD, AMO_WR} state_t;

  state_t             state;
  logic [2:0]         l_op;
  logic [1:0]         l_size;
  logic               l_uns;
  logic [3:0]         l_fn;
  logic [OFF_W-1:0]   l_off;
  logic [NB-1:0]      l_strb;
  logic [DATA_W-1:0]  l_wdata;
  logic [DATA_W-1:0]  amo_old;
  logic [CNT_W-1:0]   cnt;
  logic               resv_valid;
  logic [ADDR_W-1:0]  resv_addr;

  logic [2:0]         op_n;
  logic [OFF_W-1:0]   in_off;
  logic [ADDR_W-1:0]  in_aligned;
  logic               is_atomic;
  logic               illegal;
  logic               misal;
  logic [3:0]         size_m1;
  logic [NB-1:0]      in_strb;
  logic [DATA_W-1:0]  in_wdata;
  logic               resv_hit;
  logic               timed_out;
  logic [DATA_W-1:0]  rsp_shift;
  logic [DATA_W-1:0]  load_val;
  logic [DATA_W-1:0]  a_s, b_s, a_u, b_u;
  logic [DATA_W-1:0]  amo_new;

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = DATA_W'(8'hFF);
      2'd1:    size_mask = DATA_W'(16'hFFFF);
      2'd2:    size_mask = DATA_W'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0] s,
                                               input logic u);
    logic [DATA_W-1:0] m;
    logic              sb;
    m = size_mask(s);
    case (s)
      2'd0:    sb = v[7];
      2'd1:    sb = v[15];
      2'd2:    sb = v[31];
      default: sb = v[DATA_W-1];
    endcase
    extend = (!u && sb) ? (v | ~m) : (v & m);
  endfunction

  // Decode the incoming request and pre-compute bus lanes and AMO results
  always_comb begin
    op_n       = (bus.op > OP_AMO) ? OP_NONE : bus.op;
    in_off     = bus.addr_in[OFF_W-1:0];
    in_aligned = {bus.addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    is_atomic  = (op_n == OP_LR) || (op_n == OP_SC) || (op_n == OP_AMO);
    illegal    = ((DATA_W == 32) && (bus.size == 2'd3)) ||
                 (is_atomic && (bus.size < 2'd2)) ||
                 ((op_n == OP_AMO) && (bus.amo_fn > 4'd8));
    size_m1    = (4'd1 << bus.size) - 4'd1;
    misal      = (in_off & size_m1[OFF_W-1:0]) != '0;
    case (bus.size)
      2'd0:    in_strb = NB'(1'b1);
      2'd1:    in_strb = NB'(2'b11);
      2'd2:    in_strb = NB'(4'hF);
      default: in_strb = '1;
    endcase
    in_strb   = in_strb << in_off;
    in_wdata  = bus.wdata_in << {in_off, 3'b000};
    resv_hit  = resv_valid && (resv_addr == in_aligned);
    timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    rsp_shift = bus.rsp_data >> {l_off, 3'b000};
    load_val  = extend(rsp_shift, l_size, l_uns);
    a_s = extend(rsp_shift, l_size, 1'b0);
    b_s = extend(l_wdata, l_size, 1'b0);
    a_u = extend(rsp_shift, l_size, 1'b1);
    b_u = extend(l_wdata, l_size, 1'b1);
    case (l_fn)
      4'd1:    amo_new = a_s + b_s;
      4'd2:    amo_new = a_s ^ b_s;
      4'd3:    amo_new = a_s & b_s;
      4'd4:    amo_new = a_s | b_s;
      4'd5:    amo_new = ($signed(a_s) < $signed(b_s)) ? a_s : b_s;
      4'd6:    amo_new = ($signed(a_s) > $signed(b_s)) ? a_s : b_s;
      4'd7:    amo_new = (a_u < b_u) ? a_u : b_u;
      4'd8:    amo_new = (a_u > b_u) ? a_u : b_u;
      default: amo_new = b_s;
    endcase
    amo_new = amo_new & size_mask(l_size);
  end

  // Control FSM with registered outputs, reservation and bus timeout
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      l_op            <= OP_NONE;
      l_size          <= '0;
      l_uns           <= 1'b0;
      l_fn            <= '0;
      l_off           <= '0;
      l_strb          <= '0;
      l_wdata         <= '0;
      amo_old         <= '0;
      cnt             <= '0;
      resv_valid      <= 1'b0;
      resv_addr       <= '0;
      bus.completed   <= 1'b0;
      bus.result      <= '0;
      bus.fault       <= 1'b0;
      bus.fault_cause <= '0;
      bus.req_en      <= 1'b0;
      bus.req_mode    <= 1'b0;
      bus.req_addr    <= '0;
      bus.req_wdata   <= '0;
      bus.req_wstrb   <= '0;
    end else begin
      bus.completed   <= 1'b0;
      bus.fault       <= 1'b0;
      bus.fault_cause <= '0;
      bus.req_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enabled) begin
            l_op    <= op_n;
            l_size  <= bus.size;
            l_uns   <= bus.uns;
            l_fn    <= bus.amo_fn;
            l_off   <= in_off;
            l_strb  <= in_strb;
            l_wdata <= bus.wdata_in;
            cnt     <= '0;
            if (op_n == OP_NONE) begin
              bus.completed <= 1'b1;
            end else if (illegal) begin
              bus.completed   <= 1'b1;
              bus.fault       <= 1'b1;
              bus.fault_cause <= 3'd3;
            end else if (misal) begin
              bus.completed   <= 1'b1;
              bus.fault       <= 1'b1;
              bus.fault_cause <= ((op_n == OP_LOAD) || (op_n == OP_LR)) ? 3'd1 : 3'd2;
            end else begin
              case (op_n)
                OP_LOAD, OP_LR, OP_AMO: begin
                  bus.req_en    <= 1'b1;
                  bus.req_mode  <= 1'b0;
                  bus.req_addr  <= in_aligned;
                  bus.req_wdata <= '0;
                  bus.req_wstrb <= '0;
                  state         <= (op_n == OP_AMO) ? AMO_RD : RD_WAIT;
                  if ((op_n == OP_AMO) && resv_hit) resv_valid <= 1'b0;
                end
                OP_STORE: begin
                  bus.req_en    <= 1'b1;
                  bus.req_mode  <= 1'b1;
                  bus.req_addr  <= in_aligned;
                  bus.req_wdata <= in_wdata;
                  bus.req_wstrb <= in_strb;
                  state         <= WR_WAIT;
                  if (resv_hit) resv_valid <= 1'b0;
                end
                default: begin
                  resv_valid <= 1'b0;
                  if (resv_hit) begin
                    bus.req_en    <= 1'b1;
                    bus.req_mode  <= 1'b1;
                    bus.req_addr  <= in_aligned;
                    bus.req_wdata <= in_wdata;
                    bus.req_wstrb <= in_strb;
                    state         <= WR_WAIT;
                  end else begin
                    bus.result    <= DATA_W'(1);
                    bus.completed <= 1'b1;
                  end
                end
              endcase
            end
          end
        end
        RD_WAIT: begin
          if (bus.rsp_en) begin
            bus.result    <= load_val;
            bus.completed <= 1'b1;
            state         <= IDLE;
            if (l_op == OP_LR) begin
              resv_valid <= 1'b1;
              resv_addr  <= bus.req_addr;
            end
          end else if (timed_out) begin
            bus.completed   <= 1'b1;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 3'd4;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_WAIT: begin
          if (bus.rsp_en) begin
            if (l_op == OP_SC) bus.result <= '0;
            bus.completed <= 1'b1;
            state         <= IDLE;
          end else if (timed_out) begin
            bus.completed   <= 1'b1;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 3'd4;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        AMO_RD: begin
          if (bus.rsp_en) begin
            amo_old       <= rsp_shift & size_mask(l_size);
            bus.req_en    <= 1'b1;
            bus.req_mode  <= 1'b1;
            bus.req_wdata <= amo_new << {l_off, 3'b000};
            bus.req_wstrb <= l_strb;
            cnt           <= '0;
            state         <= AMO_WR;
          end else if (timed_out) begin
            bus.completed   <= 1'b1;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 3'd4;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        AMO_WR: begin
          if (bus.rsp_en) begin
            bus.result    <= extend(amo_old, l_size, 1'b0);
            bus.completed <= 1'b1;
            state         <= IDLE;
          end else if (timed_out) begin
            bus.completed   <= 1'b1;
            bus.fault       <= 1'b1;
            bus.fault_cause <= 3'd4;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DATA_W=32, TIMEOUT=8): directed
// requests push expected bus transactions and completions into queues that
// independent monitors pop and compare.
module tb_mem_access_unit;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_LR    = 3'd3;
  localparam logic [2:0] OP_SC    = 3'd4;
  localparam logic [2:0] OP_AMO   = 3'd5;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        fault;
    logic [2:0]  cause;
    int          ref_kind;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  logic clk;
  logic rstn;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   issue_cycle = 0;
  int   req_cycle   = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];

  mem_access_if #(.DATA_W(32), .ADDR_W(32)) bus();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Free-running clock and a cycle counter for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic expectDone(input string n, input logic [31:0] r, input logic f,
                            input logic [2:0] c, input int rk, input int lat);
    exp_t e;
    e.name = n; e.result = r; e.fault = f; e.cause = c; e.ref_kind = rk; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic expectBus(input string n, input logic m, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    bus_t b;
    b.name = n; b.mode = m; b.addr = a; b.wdata = d; b.wstrb = s;
    bus_q.push_back(b);
  endtask

  // Bus-request monitor: every req_en pulse must match a queued expectation
  always @(negedge clk) begin
    bus_t b;
    if (rstn && bus.req_en) begin
      req_cycle = cyc;
      if (bus_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL spurious_req: got req_en addr 0x%08h expected no request", bus.req_addr);
      end else begin
        b = bus_q.pop_front();
        checkOutput({b.name, ".mode"}, 32'(bus.req_mode), 32'(b.mode));
        checkOutput({b.name, ".addr"}, bus.req_addr, b.addr);
        if (b.mode) begin
          checkOutput({b.name, ".wdata"}, bus.req_wdata, b.wdata);
          checkOutput({b.name, ".wstrb"}, 32'(bus.req_wstrb), 32'(b.wstrb));
        end
      end
    end
  end

  // Completion monitor: every completed pulse must match a queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.completed) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL spurious_done: got completed result 0x%08h expected none", bus.result);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, ".result"}, bus.result, e.result);
        checkOutput({e.name, ".fault"}, 32'(bus.fault), 32'(e.fault));
        checkOutput({e.name, ".cause"}, 32'(bus.fault_cause), 32'(e.cause));
        if (e.ref_kind == 1)
          checkOutput({e.name, ".latency"}, 32'(cyc - issue_cycle), 32'(e.lat));
        else if (e.ref_kind == 2)
          checkOutput({e.name, ".latency"}, 32'(cyc - req_cycle), 32'(e.lat));
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size,
                               input logic uns, input logic [3:0] fn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.enabled  = 1'b1;
    bus.op       = op;
    bus.size     = size;
    bus.uns      = uns;
    bus.amo_fn   = fn;
    bus.addr_in  = addr;
    bus.wdata_in = wdata;
    @(posedge clk); #1;
    issue_cycle = cyc;
    bus.enabled = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input int lat);
    int n = 0;
    while (!bus.req_en && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_en) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL req_wait: got no req_en within 20 cycles expected a request");
    end
    repeat (lat) begin @(posedge clk); #1; end
    bus.rsp_en   = 1'b1;
    bus.rsp_data = data;
    @(posedge clk); #1;
    bus.rsp_en   = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL done_wait: got %0d/%0d pending expected 0/0", exp_q.size(), bus_q.size());
      exp_q.delete();
      bus_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence
  initial begin
    clk = 1'b0; rstn = 1'b0;
    bus.enabled = 1'b0; bus.op = '0; bus.size = '0; bus.uns = 1'b0; bus.amo_fn = '0;
    bus.addr_in = '0; bus.wdata_in = '0; bus.rsp_en = 1'b0; bus.rsp_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.completed", 32'(bus.completed), 32'd0);
    checkOutput("rst.fault", 32'(bus.fault), 32'd0);
    checkOutput("rst.cause", 32'(bus.fault_cause), 32'd0);
    checkOutput("rst.result", bus.result, 32'd0);
    checkOutput("rst.req_en", 32'(bus.req_en), 32'd0);
    checkOutput("rst.req_addr", bus.req_addr, 32'd0);
    checkOutput("rst.req_wdata", bus.req_wdata, 32'd0);
    checkOutput("rst.req_wstrb", 32'(bus.req_wstrb), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    expectBus("ld_b_s", 1'b0, 32'h1000, 0, 0);
    expectDone("ld_b_s", 32'hFFFF_FF80, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LOAD, 2'd0, 1'b0, 4'd0, 32'h1003, 0);
    respond(32'h80FF_0000, 1);
    waitDone();

    expectBus("ld_b_u", 1'b0, 32'h1000, 0, 0);
    expectDone("ld_b_u", 32'h0000_0080, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LOAD, 2'd0, 1'b1, 4'd0, 32'h1003, 0);
    respond(32'h80FF_0000, 0);
    waitDone();

    expectBus("ld_h_s", 1'b0, 32'h1000, 0, 0);
    expectDone("ld_h_s", 32'hFFFF_80FF, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LOAD, 2'd1, 1'b0, 4'd0, 32'h1002, 0);
    respond(32'h80FF_0000, 2);
    waitDone();

    expectBus("ld_w", 1'b0, 32'h1000, 0, 0);
    expectDone("ld_w", 32'hDEAD_BEEF, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LOAD, 2'd2, 1'b0, 4'd0, 32'h1000, 0);
    respond(32'hDEAD_BEEF, 1);
    waitDone();

    expectBus("st_h", 1'b1, 32'h2000, 32'hABCD_0000, 4'b1100);
    expectDone("st_h", 32'hDEAD_BEEF, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_STORE, 2'd1, 1'b0, 4'd0, 32'h2002, 32'h1234_ABCD);
    respond(0, 1);
    waitDone();

    expectBus("st_b", 1'b1, 32'h2000, 32'h0000_5500, 4'b0010);
    expectDone("st_b", 32'hDEAD_BEEF, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_STORE, 2'd0, 1'b0, 4'd0, 32'h2001, 32'h0000_0055);
    respond(0, 1);
    waitDone();

    expectDone("mis_ld", 32'hDEAD_BEEF, 1'b1, 3'd1, 1, 0);
    applyStimulus(OP_LOAD, 2'd2, 1'b0, 4'd0, 32'h3001, 0);
    waitDone();

    expectDone("mis_st", 32'hDEAD_BEEF, 1'b1, 3'd2, 1, 0);
    applyStimulus(OP_STORE, 2'd1, 1'b0, 4'd0, 32'h2001, 32'h1);
    waitDone();

    expectDone("ill_lr_b", 32'hDEAD_BEEF, 1'b1, 3'd3, 1, 0);
    applyStimulus(OP_LR, 2'd0, 1'b0, 4'd0, 32'h5000, 0);
    waitDone();

    expectDone("ill_ld_d", 32'hDEAD_BEEF, 1'b1, 3'd3, 1, 0);
    applyStimulus(OP_LOAD, 2'd3, 1'b0, 4'd0, 32'h1000, 0);
    waitDone();

    expectDone("op_none", 32'hDEAD_BEEF, 1'b0, 3'd0, 1, 0);
    applyStimulus(3'd7, 2'd2, 1'b0, 4'd0, 32'h1000, 0);
    waitDone();

    expectBus("amo_add.rd", 1'b0, 32'h4000, 0, 0);
    expectBus("amo_add.wr", 1'b1, 32'h4000, 32'h0000_0015, 4'b1111);
    expectDone("amo_add", 32'h0000_0010, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_AMO, 2'd2, 1'b0, 4'd1, 32'h4000, 32'd5);
    respond(32'h0000_0010, 1);
    respond(0, 1);
    waitDone();

    expectBus("amo_min.rd", 1'b0, 32'h4000, 0, 0);
    expectBus("amo_min.wr", 1'b1, 32'h4000, 32'hFFFF_FFFF, 4'b1111);
    expectDone("amo_min", 32'h0000_0005, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_AMO, 2'd2, 1'b0, 4'd5, 32'h4000, 32'hFFFF_FFFF);
    respond(32'h0000_0005, 1);
    respond(0, 2);
    waitDone();

    expectBus("amo_minu.rd", 1'b0, 32'h4000, 0, 0);
    expectBus("amo_minu.wr", 1'b1, 32'h4000, 32'h0000_0005, 4'b1111);
    expectDone("amo_minu", 32'h0000_0005, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_AMO, 2'd2, 1'b0, 4'd7, 32'h4000, 32'hFFFF_FFFF);
    respond(32'h0000_0005, 1);
    respond(0, 1);
    waitDone();

    expectBus("lr", 1'b0, 32'h5000, 0, 0);
    expectDone("lr", 32'hCAFE_F00D, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LR, 2'd2, 1'b0, 4'd0, 32'h5000, 0);
    respond(32'hCAFE_F00D, 1);
    waitDone();

    expectBus("sc_ok", 1'b1, 32'h5000, 32'h0000_0077, 4'b1111);
    expectDone("sc_ok", 32'h0000_0000, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_SC, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h77);
    respond(0, 1);
    waitDone();

    expectDone("sc_again", 32'h0000_0001, 1'b0, 3'd0, 1, 0);
    applyStimulus(OP_SC, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h77);
    waitDone();

    expectBus("lr2", 1'b0, 32'h5000, 0, 0);
    expectDone("lr2", 32'h0000_0011, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LR, 2'd2, 1'b0, 4'd0, 32'h5000, 0);
    respond(32'h0000_0011, 1);
    waitDone();

    expectBus("st_resv", 1'b1, 32'h5000, 32'h0000_0022, 4'b1111);
    expectDone("st_resv", 32'h0000_0011, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_STORE, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h22);
    respond(0, 1);
    waitDone();

    expectDone("sc_after_st", 32'h0000_0001, 1'b0, 3'd0, 1, 0);
    applyStimulus(OP_SC, 2'd2, 1'b0, 4'd0, 32'h5000, 32'h33);
    waitDone();

    expectBus("to_ld", 1'b0, 32'h6000, 0, 0);
    expectDone("to_ld", 32'h0000_0001, 1'b1, 3'd4, 2, 8);
    applyStimulus(OP_LOAD, 2'd2, 1'b0, 4'd0, 32'h6000, 0);
    waitDone();
    bus.rsp_en   = 1'b1;
    bus.rsp_data = 32'h1234_5678;
    @(posedge clk); #1;
    bus.rsp_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    expectBus("ld_after_to", 1'b0, 32'h7000, 0, 0);
    expectDone("ld_after_to", 32'h0000_00AB, 1'b0, 3'd0, 0, 0);
    applyStimulus(OP_LOAD, 2'd0, 1'b1, 4'd0, 32'h7002, 0);
    respond(32'h00AB_0000, 1);
    waitDone();

    expectBus("rst_mid", 1'b0, 32'h8000, 0, 0);
    applyStimulus(OP_LOAD, 2'd2, 1'b0, 4'd0, 32'h8000, 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid.result", bus.result, 32'd0);
    checkOutput("rst_mid.req_addr", bus.req_addr, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.rsp_en   = 1'b1;
    bus.rsp_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.rsp_en   = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid.result_after", bus.result, 32'd0);
    checkOutput("leftover_done", 32'(exp_q.size()), 32'd0);
    checkOutput("leftover_bus", 32'(bus_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
